// File: rtl/viterbi_acs.sv
`default_nettype none
// ============================================================================
// Module  : viterbi_acs
// Brief   : Add-compare-select for the K=3 rate-1/2 (111/101) Viterbi decoder.
//           Optional metric normalization: define ACS_NORM_EN.
// Revision: 1.0
// ============================================================================
module viterbi_acs #(
  parameter int PM_W       = 8,
  parameter int PM_INIT    = 8,
  parameter int FRAME_SYMS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_acs,
  input  logic [1:0]      i_Rx,
  output logic [3:0]      o_surv,
  output logic            o_valid,
  output logic            o_last,
  output logic [1:0]      o_best_state,
  output logic [PM_W-1:0] o_min_pm
);

  localparam int              CNT_W    = (FRAME_SYMS > 1) ? $clog2(FRAME_SYMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_SYMS - 1);
  localparam logic [PM_W-1:0]  INIT_PM  = PM_W'(PM_INIT);
  localparam logic [0:0]       ST_FRESH = 1'b0;
  localparam logic [0:0]       ST_RUN   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [PM_W-1:0]  pm_q [4];
  logic [PM_W-1:0]  pm_d [4];
  logic [3:0]       surv_q, surv_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [1:0]       best_q, best_d;
  logic [PM_W-1:0]  min_pm_q, min_pm_d;

  logic             use_init;
  logic             is_last;
  logic [PM_W-1:0]  pm_cur [4];
  logic [PM_W-1:0]  pm_acs [4];
  logic [PM_W-1:0]  pm_new [4];
  logic [3:0]       dec;
  logic [1:0]       best_idx;
  logic [PM_W-1:0]  best_pm;

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FRESH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (en_acs) state_d = is_last ? ST_FRESH : ST_RUN;
  end

  assign use_init = (state_q == ST_FRESH);
  assign is_last  = en_acs && (sym_cnt_q == LAST_CNT);

  // Predecessors of n are {n0,0} and {n0,1}; input bit is n1.
  always_comb begin : acs
    logic [1:0]      nb, p0, p1, exp0, exp1;
    logic [PM_W:0]   cand0, cand1, win;
    nb    = '0;
    p0    = '0;
    p1    = '0;
    exp0  = '0;
    exp1  = '0;
    cand0 = '0;
    cand1 = '0;
    win   = '0;
    dec   = '0;
    for (int s = 0; s < 4; s++) begin
      pm_cur[s] = use_init ? ((s == 0) ? '0 : INIT_PM) : pm_q[s];
    end
    for (int n = 0; n < 4; n++) begin
      nb     = 2'(n);
      p0     = {nb[0], 1'b0};
      p1     = {nb[0], 1'b1};
      exp0   = {nb[1] ^ p0[1] ^ p0[0], nb[1] ^ p0[0]};
      exp1   = {nb[1] ^ p1[1] ^ p1[0], nb[1] ^ p1[0]};
      cand0  = {1'b0, pm_cur[p0]} + (PM_W+1)'(hamming(i_Rx, exp0));
      cand1  = {1'b0, pm_cur[p1]} + (PM_W+1)'(hamming(i_Rx, exp1));
      dec[n] = (cand1 < cand0);
      win    = dec[n] ? cand1 : cand0;
      pm_acs[n] = win[PM_W] ? '1 : win[PM_W-1:0];
    end
  end

  always_comb begin : norm
`ifdef ACS_NORM_EN
    logic all_hi;
    all_hi = 1'b1;
    for (int s = 0; s < 4; s++) all_hi = all_hi & pm_acs[s][PM_W-1];
`endif
    for (int s = 0; s < 4; s++) pm_new[s] = pm_acs[s];
`ifdef ACS_NORM_EN
    if (all_hi) begin
      for (int s = 0; s < 4; s++) pm_new[s][PM_W-1] = 1'b0;
    end
`endif
  end

  // Strict compare keeps ties on the lowest state index.
  always_comb begin : best_sel
    best_idx = 2'd0;
    best_pm  = pm_new[0];
    for (int s = 1; s < 4; s++) begin
      if (pm_new[s] < best_pm) begin
        best_pm  = pm_new[s];
        best_idx = 2'(s);
      end
    end
  end

  // Output / datapath next-value logic
  always_comb begin
    sym_cnt_d = sym_cnt_q;
    for (int s = 0; s < 4; s++) pm_d[s] = pm_q[s];
    surv_d    = '0;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    best_d    = best_q;
    min_pm_d  = min_pm_q;
    if (en_acs) begin
      for (int s = 0; s < 4; s++) pm_d[s] = pm_new[s];
      surv_d    = dec;
      valid_d   = 1'b1;
      last_d    = is_last;
      sym_cnt_d = is_last ? '0 : sym_cnt_q + CNT_W'(1);
      if (is_last) begin
        best_d   = best_idx;
        min_pm_d = best_pm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt_q <= '0;
      pm_q[0]   <= '0;
      pm_q[1]   <= INIT_PM;
      pm_q[2]   <= INIT_PM;
      pm_q[3]   <= INIT_PM;
      surv_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      best_q    <= '0;
      min_pm_q  <= '0;
    end else begin
      sym_cnt_q <= sym_cnt_d;
      for (int s = 0; s < 4; s++) pm_q[s] <= pm_d[s];
      surv_q    <= surv_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      best_q    <= best_d;
      min_pm_q  <= min_pm_d;
    end
  end

  assign o_surv       = surv_q;
  assign o_valid      = valid_q;
  assign o_last       = last_q;
  assign o_best_state = best_q;
  assign o_min_pm     = min_pm_q;

endmodule
`default_nettype wire
